// File: rtl/bitcell_pkg.sv
// Shared types for the bitcell array controller: FSM states, access phase, op codes.
package bitcell_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    PULSE = 3'd2,
    HOLD  = 3'd3,
    RESP  = 3'd4
  } state_e;

  // ACCESS is the requested operation; VERIFY is the internal read-back after a write.
  typedef enum logic {
    PH_ACCESS = 1'b0,
    PH_VERIFY = 1'b1
  } phase_e;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

endpackage

// File: rtl/bitcell_array_ctrl_if.sv
// Request/response handshake bundle between a bus initiator (master) and the array controller (slave).
interface bitcell_array_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/row_decoder.sv
// Row address to one-hot select; oor flags addresses at or beyond DEPTH (those never select a row).
module row_decoder #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  output logic [DEPTH-1:0]  onehot,
  output logic              oor
);
  always_comb begin
    oor    = int'(addr) >= DEPTH;
    onehot = '0;
    for (int i = 0; i < DEPTH; i++) begin
      onehot[i] = en && (int'(addr) == i);
    end
  end
endmodule

// File: rtl/bitcell_array_ctrl.sv
// Sequences one word read/write at a time onto a NAND-latch bitcell array (setup, select pulse, hold).
// Optional write read-back check is enabled by defining BITCELL_READBACK_VERIFY_EN.
module bitcell_array_ctrl
  import bitcell_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int ADDR_W    = $clog2(DEPTH),
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  bitcell_array_ctrl_if.slave bus,
  output logic [DEPTH-1:0]    arr_sel,
  output logic                arr_r_w,
  output logic [DATA_W-1:0]   arr_in,
  input  logic [DATA_W-1:0]   arr_out
);

`ifdef BITCELL_READBACK_VERIFY_EN
  localparam bit VERIFY_EN = 1'b1;
`else
  localparam bit VERIFY_EN = 1'b0;
`endif

  localparam int CNT_MAX = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYC - 1);

  state_e              state_q, state_d;
  phase_e              phase_q, phase_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                live_q, live_d;

  logic                hs;
  logic                op_rw;
  logic                active;
  logic [ADDR_W-1:0]   dec_addr;
  logic                dec_oor;

  // In IDLE the decoder only range-checks the incoming address; it selects a row only in PULSE.
  assign dec_addr = (state_q == IDLE) ? bus.req_addr : addr_q;

  row_decoder #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_row_decoder (
    .en     (state_q == PULSE),
    .addr   (dec_addr),
    .onehot (arr_sel),
    .oor    (dec_oor)
  );

  assign bus.req_ready = live_q && (state_q == IDLE);
  assign hs            = bus.req_valid && bus.req_ready;
  assign op_rw         = (phase_q == PH_VERIFY) ? OP_READ : we_q;
  assign active        = (state_q == SETUP) || (state_q == PULSE) || (state_q == HOLD);

  // r_w and data are a pure function of state, so they cannot move while a select is high.
  assign arr_r_w = active ? op_rw : OP_READ;
  assign arr_in  = (active && (op_rw == OP_WRITE)) ? wdata_q : '0;

  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = bus.rsp_valid ? rdata_q : '0;
  assign bus.rsp_err   = bus.rsp_valid && err_q;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    live_d  = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (hs) begin
          we_d    = bus.req_we;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          rdata_d = '0;
          err_d   = dec_oor;
          phase_d = PH_ACCESS;
          cnt_d   = '0;
          state_d = dec_oor ? RESP : SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          cnt_d   = '0;
          state_d = PULSE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PULSE: begin
        if (cnt_q == PULSE_LAST) begin
          cnt_d   = '0;
          state_d = HOLD;
          if (op_rw == OP_READ) begin
            rdata_d = arr_out;
            if (phase_q == PH_VERIFY) begin
              err_d = (arr_out != wdata_q);
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HOLD: begin
        if (VERIFY_EN && (we_q == OP_WRITE) && (phase_q == PH_ACCESS)) begin
          phase_d = PH_VERIFY;
          state_d = SETUP;
        end else begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      phase_q <= PH_ACCESS;
      cnt_q   <= '0;
      we_q    <= OP_READ;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      live_q  <= live_d;
    end
  end

endmodule

// File: tb/tb_bitcell_array_ctrl.sv
// Bench for bitcell_array_ctrl: bitcell array model, transaction-level reference, per-cycle compare.
module tb_bitcell_array_ctrl;

  localparam int S  = 1;
  localparam int P  = 2;
  localparam int D  = 16;
`ifdef BITCELL_READBACK_VERIFY_EN
  localparam bit VER = 1'b1;
`else
  localparam bit VER = 1'b0;
`endif
  localparam int LAT_ACC = S + P + 2;
  localparam int LAT_WR  = VER ? 2 * (S + P + 1) + 1 : LAT_ACC;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bitcell_array_ctrl_if #(.DATA_W(8), .ADDR_W(4)) bus ();
  logic [15:0] arr_sel;
  logic        arr_r_w;
  logic [7:0]  arr_in;
  logic [7:0]  arr_out;

  bitcell_array_ctrl #(.DATA_W(8), .DEPTH(16), .ADDR_W(4), .SETUP_CYC(S), .PULSE_CYC(P)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .arr_sel(arr_sel), .arr_r_w(arr_r_w), .arr_in(arr_in), .arr_out(arr_out)
  );

  bitcell_array_ctrl_if #(.DATA_W(8), .ADDR_W(4)) b12 ();
  logic [11:0] sel12;
  logic        rw12;
  logic [7:0]  in12;
  logic [7:0]  out12;
  assign out12 = 8'h00;

  bitcell_array_ctrl #(.DATA_W(8), .DEPTH(12), .ADDR_W(4), .SETUP_CYC(S), .PULSE_CYC(P)) dut12 (
    .clk(clk), .rst_n(rst_n), .bus(b12),
    .arr_sel(sel12), .arr_r_w(rw12), .arr_in(in12), .arr_out(out12)
  );

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;
  bit corrupt  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Bitcell array: selected row drives arr_out; a write strobe with select stores arr_in.
  logic [7:0] mem     [16];
  logic [7:0] ref_mem [16];

  always_comb begin
    arr_out = 8'h00;
    for (int i = 0; i < 16; i++) begin
      if (arr_sel[i] && !(corrupt && !arr_r_w)) arr_out = mem[i];
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 16; i++) begin
      if (arr_sel[i] && arr_r_w) mem[i] <= arr_in;
    end
  end

  // Reference: one transaction at a time, timed as cycles elapsed since its handshake.
  bit         m_live = 1'b0;
  bit         m_busy = 1'b0;
  bit         m_we, m_oor, m_err;
  int         m_k, m_lat, m_addr;
  logic [7:0] m_wd, m_rd;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_live = 1'b0;
      m_busy = 1'b0;
      m_k    = 0;
    end else if (!m_busy) begin
      if (m_live && bus.req_valid) begin
        m_busy = 1'b1;
        m_k    = 1;
        m_we   = bus.req_we;
        m_addr = int'(bus.req_addr);
        m_wd   = bus.req_wdata;
        m_oor  = (m_addr >= D);
        if (m_oor) begin
          m_rd = 8'h00; m_err = 1'b1; m_lat = 1;
        end else if (m_we) begin
          ref_mem[m_addr] = m_wd;
          m_rd  = VER ? (corrupt ? 8'h00 : m_wd) : 8'h00;
          m_err = VER && corrupt && (m_wd != 8'h00);
          m_lat = LAT_WR;
        end else begin
          m_rd = ref_mem[m_addr]; m_err = 1'b0; m_lat = LAT_ACC;
        end
      end
      m_live = 1'b1;
    end else if (m_k >= m_lat) begin
      if (bus.rsp_ready) m_busy = 1'b0;
    end else begin
      m_k++;
    end
  end

  function automatic void exp_arr(output logic [15:0] sel, output logic rw, output logic [7:0] din);
    int base;
    int off;
    bit wr;
    sel = '0; rw = 1'b0; din = '0;
    if (m_busy && !m_oor && m_k < m_lat) begin
      base = (m_k > S + P + 1) ? S + P + 1 : 0;
      off  = m_k - base;
      wr   = m_we && (base == 0);
      rw   = wr;
      din  = wr ? m_wd : 8'h00;
      if (off > S && off <= S + P) sel = 16'b1 << m_addr;
    end
  endfunction

  logic [15:0] e_sel;
  logic        e_rw;
  logic [7:0]  e_in;

  always @(negedge clk) begin
    if (chk_en) begin
      exp_arr(e_sel, e_rw, e_in);
      check("req_ready", 64'(bus.req_ready), 64'(m_live && !m_busy));
      check("rsp_valid", 64'(bus.rsp_valid), 64'(m_busy && m_k >= m_lat));
      check("arr_sel", 64'(arr_sel), 64'(e_sel));
      check("arr_r_w", 64'(arr_r_w), 64'(e_rw));
      check("arr_in", 64'(arr_in), 64'(e_in));
      check("sel_onehot0", 64'($onehot0(arr_sel)), 64'd1);
      if (m_busy && m_k >= m_lat) begin
        check("rsp_rdata", 64'(bus.rsp_rdata), 64'(m_rd));
        check("rsp_err", 64'(bus.rsp_err), 64'(m_err));
      end
    end
  end

  int          last_lat, last_sel_cyc;
  logic [15:0] last_sel_seen;
  bit          last_rw_and, last_rdy_seen, last_err;
  logic [7:0]  last_rd;

  task automatic send(input bit we, input int addr, input logic [7:0] wd, input bit hold);
    int t = 0;
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = 4'(addr); bus.req_wdata = wd;
    while (bus.req_ready !== 1'b1 && t < 60) begin @(negedge clk); t++; end
    if (t >= 60) check("req_timeout", 64'(bus.req_ready), 64'd1);
    @(negedge clk);
    if (!hold) bus.req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input bit hold_rsp);
    int t = 0;
    bus.rsp_ready = !hold_rsp;
    last_lat = 1; last_sel_cyc = 0; last_sel_seen = '0; last_rw_and = 1'b1; last_rdy_seen = 1'b0;
    while (bus.rsp_valid !== 1'b1 && t < 60) begin
      if (arr_sel != '0) begin
        last_sel_cyc++;
        last_sel_seen |= arr_sel;
        if (last_sel_cyc <= P) last_rw_and &= arr_r_w;
      end
      last_rdy_seen |= bus.req_ready;
      @(negedge clk); last_lat++; t++;
    end
    if (t >= 60) check("rsp_timeout", 64'(bus.rsp_valid), 64'd1);
    last_rdy_seen |= bus.req_ready;
    last_rd  = bus.rsp_rdata;
    last_err = bus.rsp_err;
  endtask

  task automatic finish_rsp(input int bp);
    repeat (bp) @(negedge clk);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int t;
    int bp;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0; bus.rsp_ready = 1'b1;
    b12.req_valid = 1'b0; b12.req_we = 1'b0; b12.req_addr = '0; b12.req_wdata = '0; b12.rsp_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      mem[i]     = 8'($urandom);
      ref_mem[i] = mem[i];
    end

    // Reset with a pending request: nothing is accepted, ready rises one cycle after release.
    bus.req_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk_en = 1'b1;
      check("rst_arr_sel", 64'(arr_sel), 64'd0);
      check("rst_req_ready", 64'(bus.req_ready), 64'd0);
      check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    end
    rst_n = 1'b1; bus.req_valid = 1'b0;
    @(negedge clk);
    check("rdy_after_rst", 64'(bus.req_ready), 64'd1);

    // Write then read row 3.
    send(1'b1, 3, 8'hA5, 1'b0); wait_rsp(1'b0);
    check("wr_latency", 64'(last_lat), VER ? 64'd9 : 64'd5);
    check("wr_sel_mask", 64'(last_sel_seen), 64'h0008);
    check("wr_sel_cycles", 64'(last_sel_cyc), VER ? 64'd4 : 64'd2);
    check("wr_rw_during_sel", 64'(last_rw_and), 64'd1);
    finish_rsp(0);
    send(1'b0, 3, 8'h00, 1'b0); wait_rsp(1'b0);
    check("rd_latency", 64'(last_lat), 64'd5);
    check("rd_rdata", 64'(last_rd), 64'hA5);
    check("rd_err", 64'(last_err), 64'd0);
    finish_rsp(0);

    // Back-to-back writes to row 15 with req_valid held high.
    send(1'b1, 15, 8'h00, 1'b1);
    bus.req_wdata = 8'hFF;
    wait_rsp(1'b0);
    check("b2b_ready_low", 64'(last_rdy_seen), 64'd0);
    finish_rsp(0);
    send(1'b1, 15, 8'hFF, 1'b0); wait_rsp(1'b0); finish_rsp(0);
    send(1'b0, 15, 8'h00, 1'b0); wait_rsp(1'b0);
    check("b2b_rdata", 64'(last_rd), 64'hFF);
    finish_rsp(0);

    // Response backpressure.
    send(1'b1, 7, 8'h3C, 1'b0); wait_rsp(1'b0); finish_rsp(0);
    send(1'b0, 7, 8'h00, 1'b0); wait_rsp(1'b1);
    repeat (4) begin
      check("bp_rsp_valid", 64'(bus.rsp_valid), 64'd1);
      check("bp_rdata", 64'(bus.rsp_rdata), 64'h3C);
      check("bp_req_ready", 64'(bus.req_ready), 64'd0);
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_released", 64'(bus.rsp_valid), 64'd0);

    // Reset during the select pulse of a read.
    send(1'b0, 3, 8'h00, 1'b0);
    t = 0;
    while (arr_sel == '0 && t < 20) begin @(negedge clk); t++; end
    check("midrst_pulse_seen", 64'(arr_sel), 64'h0008);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_sel", 64'(arr_sel), 64'd0);
    check("midrst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_ready", 64'(bus.req_ready), 64'd1);

    // Out-of-range address on a 12-row instance.
    b12.req_valid = 1'b1; b12.req_addr = 4'd13;
    t = 0;
    while (b12.req_ready !== 1'b1 && t < 20) begin @(negedge clk); t++; end
    @(negedge clk);
    b12.req_valid = 1'b0;
    check("oor_rsp_valid", 64'(b12.rsp_valid), 64'd1);
    check("oor_err", 64'(b12.rsp_err), 64'd1);
    check("oor_rdata", 64'(b12.rsp_rdata), 64'd0);
    check("oor_array_idle", 64'({sel12, rw12, in12}), 64'd0);
    @(negedge clk);
    check("oor_done", 64'(b12.rsp_valid), 64'd0);
    check("oor_ready", 64'(b12.req_ready), 64'd1);

`ifdef BITCELL_READBACK_VERIFY_EN
    corrupt = 1'b1;
    send(1'b1, 5, 8'h5A, 1'b0); wait_rsp(1'b0);
    check("verify_bad_err", 64'(last_err), 64'd1);
    check("verify_bad_rdata", 64'(last_rd), 64'h00);
    check("verify_latency", 64'(last_lat), 64'd9);
    finish_rsp(0);
    corrupt = 1'b0;
    send(1'b1, 5, 8'h5A, 1'b0); wait_rsp(1'b0);
    check("verify_ok_err", 64'(last_err), 64'd0);
    check("verify_ok_rdata", 64'(last_rd), 64'h5A);
    finish_rsp(0);
`else
    send(1'b1, 5, 8'h5A, 1'b0); wait_rsp(1'b0);
    check("wr_rdata_zero", 64'(last_rd), 64'h00);
    check("wr_err_zero", 64'(last_err), 64'd0);
    finish_rsp(0);
`endif

    // Randomised traffic with random backpressure and idle gaps.
    for (int n = 0; n < 80; n++) begin
      bp = $urandom_range(0, 3);
      send(1'($urandom_range(0, 1)), $urandom_range(0, 15), 8'($urandom), 1'b0);
      wait_rsp(bp != 0);
      finish_rsp(bp);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
